// File: rtl/gate_vector_sequencer.sv
// ---------------------------------------------------------------------------
// gate_vector_sequencer
//
// Clocked stimulus/check controller for a small combinational gate. On start
// it walks the gate inputs through every vector 0..2^N_IN-1, holds each vector
// for SETTLE_CYC clocks, samples the gate output and compares it with the
// TRUTH table. It reports a mismatch count, the first failing vector and an
// overall pass flag for the sweep.
//
// Parameters
//   N_IN        number of gate inputs (vectors 0..2^N_IN-1)
//   SETTLE_CYC  clocks a vector is held before sampling (0 allowed)
//   TRUTH       expected output, bit i = expected dut_y for stim == i
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset, overrides everything
//   start       begin a sweep, honoured only while idle
//   dut_y       output of the gate under test, sampled only in CHECK
//   stim        gate inputs, MSB = first gate input
//   busy        high from the cycle after start acceptance until DONE exits
//   done        one-cycle pulse when the sweep completes
//   pass        last completed sweep had zero mismatches, held until next start
//   err_count   mismatches in the current/last sweep
//   fail_valid  sticky, at least one mismatch in this sweep
//   fail_vec    first mismatching vector, meaningful when fail_valid is set
// ---------------------------------------------------------------------------
module gate_vector_sequencer #(
   parameter int unsigned            N_IN       = 2,
   parameter int unsigned            SETTLE_CYC = 2,
   parameter logic [(1<<N_IN)-1:0]   TRUTH      = 4'b0111
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              dut_y,
   output logic [N_IN-1:0]   stim,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic              fail_valid,
   output logic [N_IN-1:0]   fail_vec
);

   localparam int unsigned ERR_W = N_IN + 1;
   localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

   localparam logic [N_IN-1:0]  IDX_LAST    = '1;
   localparam logic [N_IN-1:0]  IDX_ONE     = N_IN'(1);
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state;
   logic [N_IN-1:0]   idx;
   logic [CNT_W-1:0]  settle_cnt;

   logic              mismatch_c;
   logic [ERR_W-1:0]  err_inc_c;
   logic              last_vec_c;

   // Comparison of the sampled gate output against the expected table entry
   always_comb begin
      mismatch_c = 1'b0;
      err_inc_c  = err_count;
      last_vec_c = 1'b0;
      mismatch_c = (dut_y != TRUTH[idx]);
      err_inc_c  = err_count + ERR_ONE;
      last_vec_c = (idx == IDX_LAST);
   end

   // Sweep sequencer: state, stimulus and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         stim       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         // done is a pulse: only the CHECK->DONE transition raises it
         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_DRIVE;
                  busy       <= 1'b1;
                  idx        <= '0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  pass       <= 1'b0;
               end
            end

            S_DRIVE: begin
               stim       <= idx;
               settle_cnt <= SETTLE_LOAD;
               if (SETTLE_CYC > 0) begin
                  state <= S_SETTLE;
               end else begin
                  state <= S_CHECK;
               end
            end

            // Counter was loaded with SETTLE_CYC; leaving on 1 gives exactly
            // SETTLE_CYC cycles in this state.
            S_SETTLE: begin
               settle_cnt <= settle_cnt - CNT_ONE;
               if (settle_cnt == CNT_ONE) begin
                  state <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (mismatch_c) begin
                  err_count <= err_inc_c;
                  if (!fail_valid) begin
                     fail_vec   <= idx;
                     fail_valid <= 1'b1;
                  end
               end
               if (last_vec_c) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  // Include this final comparison in the verdict
                  pass  <= (err_count == '0) && !mismatch_c;
               end else begin
                  idx   <= idx + IDX_ONE;
                  state <= S_DRIVE;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gate_vector_sequencer
//
// Directed bench for gate_vector_sequencer. A behavioural gate model selected
// by gate_mode (0 = NAND, 1 = stuck-at-1, 2 = AND) closes the loop on the
// default instance; a second instance sweeps a 3-input NAND with no settle.
// Edge numbering inside a sweep counts edges after the start edge, so a done
// seen after edge 16 is "clock 17" counting the start edge as clock 1.
// ---------------------------------------------------------------------------
module tb_gate_vector_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       start3;
   int         gate_mode;

   logic [1:0] stim;
   logic       busy, done, pass, fail_valid, dut_y;
   logic [2:0] err_count;
   logic [1:0] fail_vec;

   logic [2:0] stim3;
   logic       busy3, done3, pass3, fail_valid3, dut_y3;
   logic [3:0] err_count3;
   logic [2:0] fail_vec3;

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dut_y  = (gate_mode == 0) ? ~&stim :
                   (gate_mode == 1) ? 1'b1   : &stim;
   assign dut_y3 = ~&stim3;

   gate_vector_sequencer u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dut_y      (dut_y),
      .stim       (stim),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_valid (fail_valid),
      .fail_vec   (fail_vec)
   );

   gate_vector_sequencer #(
      .N_IN       (3),
      .SETTLE_CYC (0),
      .TRUTH      (8'h7F)
   ) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .start      (start3),
      .dut_y      (dut_y3),
      .stim       (stim3),
      .busy       (busy3),
      .done       (done3),
      .pass       (pass3),
      .err_count  (err_count3),
      .fail_valid (fail_valid3),
      .fail_vec   (fail_vec3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One sweep on u_dut. Optional stimulus tracking, start re-pulses at
   // clocks 3 and 16, and a reset applied so it is sampled at edge rst_at.
   task automatic sweep(input int mode, input bit chk_stim, input bit repulse,
                        input int rst_at, output int done_at, output int n_done);
      gate_mode = mode;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("pass_cleared", 32'(pass), 32'd0);
      done_at = -1;
      n_done  = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (chk_stim && n <= 13 && (n % 4) == 1)
            check("stim_new_vec", 32'(stim), 32'((n - 1) / 4));
         if (chk_stim && n <= 16 && (n % 4) == 0)
            check("stim_held", 32'(stim), 32'((n - 4) / 4));
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = n;
         end
         if (repulse) start = (n == 1 || n == 14);
         if (rst_at > 0 && n == rst_at) begin
            check("rst_stim", 32'(stim), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_pass", 32'(pass), 32'd0);
            check("rst_err_count", 32'(err_count), 32'd0);
            check("rst_fail_valid", 32'(fail_valid), 32'd0);
            check("rst_fail_vec", 32'(fail_vec), 32'd0);
            rst = 1'b0;
         end
         if (rst_at > 0 && n == rst_at - 1) rst = 1'b1;
      end
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int da;
      int nd;
      n_checks  = 0;
      n_fail    = 0;
      gate_mode = 0;
      rst       = 1'b1;
      start     = 1'b0;
      start3    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_stim", 32'(stim), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_pass", 32'(pass), 32'd0);
      check("reset_err_count", 32'(err_count), 32'd0);
      check("reset_fail_valid", 32'(fail_valid), 32'd0);
      check("reset_fail_vec", 32'(fail_vec), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Correct NAND
      sweep(0, 1'b1, 1'b0, 0, da, nd);
      check("nand_done_at", 32'(da), 32'd16);
      check("nand_done_count", 32'(nd), 32'd1);
      check("nand_pass", 32'(pass), 32'd1);
      check("nand_err_count", 32'(err_count), 32'd0);
      check("nand_fail_valid", 32'(fail_valid), 32'd0);
      check("nand_busy_after", 32'(busy), 32'd0);
      check("nand_stim_holds", 32'(stim), 32'd3);

      // Stuck-at-1 output
      sweep(1, 1'b0, 1'b0, 0, da, nd);
      check("sa1_done_at", 32'(da), 32'd16);
      check("sa1_err_count", 32'(err_count), 32'd1);
      check("sa1_fail_valid", 32'(fail_valid), 32'd1);
      check("sa1_fail_vec", 32'(fail_vec), 32'd3);
      check("sa1_pass", 32'(pass), 32'd0);

      // AND gate against NAND table
      sweep(2, 1'b0, 1'b0, 0, da, nd);
      check("and_err_count", 32'(err_count), 32'd4);
      check("and_fail_vec", 32'(fail_vec), 32'd0);
      check("and_pass", 32'(pass), 32'd0);

      // start pulses while busy are ignored
      sweep(2, 1'b0, 1'b1, 0, da, nd);
      check("repulse_done_at", 32'(da), 32'd16);
      check("repulse_done_count", 32'(nd), 32'd1);
      check("repulse_err_count", 32'(err_count), 32'd4);
      check("repulse_fail_vec", 32'(fail_vec), 32'd0);
      check("repulse_busy_after", 32'(busy), 32'd0);

      // Reset at clock 9 of a failing sweep, then a clean sweep
      sweep(2, 1'b0, 1'b0, 8, da, nd);
      check("abort_done_count", 32'(nd), 32'd0);
      check("abort_pass", 32'(pass), 32'd0);
      check("abort_err_count", 32'(err_count), 32'd0);
      sweep(0, 1'b0, 1'b0, 0, da, nd);
      check("post_rst_done_at", 32'(da), 32'd16);
      check("post_rst_pass", 32'(pass), 32'd1);
      check("post_rst_err_count", 32'(err_count), 32'd0);

      // 3-input NAND, no settle window
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      da = -1;
      nd = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done3) begin
            nd++;
            if (da < 0) da = n;
         end
      end
      check("n3_done_at", 32'(da), 32'd16);
      check("n3_done_count", 32'(nd), 32'd1);
      check("n3_pass", 32'(pass3), 32'd1);
      check("n3_err_count", 32'(err_count3), 32'd0);
      check("n3_fail_valid", 32'(fail_valid3), 32'd0);
      check("n3_stim_holds", 32'(stim3), 32'd7);
      check("n3_busy_after", 32'(busy3), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
